// File: rtl/sseg_capture_if.sv
// Bus bundle for the seven-segment capture block: multiplexed display lines in,
// reassembled frame value and status out.
interface sseg_capture_if;
    logic [7:0]  SSEG_CA;
    logic [3:0]  SSEG_AN;
    logic [15:0] VALUE;
    logic [3:0]  DP;
    logic        VALID;
    logic        DIGIT_ERR;
    logic        STALE;

    // master drives the display lines (display driver or bench side)
    modport master (
        output SSEG_CA, SSEG_AN,
        input  VALUE, DP, VALID, DIGIT_ERR, STALE
    );

    modport slave (
        input  SSEG_CA, SSEG_AN,
        output VALUE, DP, VALID, DIGIT_ERR, STALE
    );
endinterface

// File: rtl/sseg_capture.sv
// Samples a multiplexed active-low seven-segment bus, decodes each settled digit
// back to a hex nibble and publishes the 16-bit value once all four digits are seen.
module sseg_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic           CLK,
    input  logic           RST,
    sseg_capture_if.slave  bus
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FIRE_AT = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;
    localparam logic [SCW-1:0] SC_MAX  = SCW'(SETTLE_CYCLES);
    localparam logic [SCW-1:0] SC_FIRE = SCW'(FIRE_AT);
    localparam logic [TCW-1:0] TMO_MAX = TCW'(TIMEOUT_CYCLES);
    localparam logic [TCW-1:0] TMO_HIT = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]    BUS_IDLE = 12'hFFF;

    // {valid, nibble}; valid=0 for any pattern outside the hex font
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = {1'b1, 4'h0};
            7'b1111001: seg_decode = {1'b1, 4'h1};
            7'b0100100: seg_decode = {1'b1, 4'h2};
            7'b0110000: seg_decode = {1'b1, 4'h3};
            7'b0011001: seg_decode = {1'b1, 4'h4};
            7'b0010010: seg_decode = {1'b1, 4'h5};
            7'b0000010: seg_decode = {1'b1, 4'h6};
            7'b1111000: seg_decode = {1'b1, 4'h7};
            7'b0000000: seg_decode = {1'b1, 4'h8};
            7'b0011000: seg_decode = {1'b1, 4'h9};
            7'b0001000: seg_decode = {1'b1, 4'hA};
            7'b0000011: seg_decode = {1'b1, 4'hB};
            7'b1000110: seg_decode = {1'b1, 4'hC};
            7'b0100001: seg_decode = {1'b1, 4'hD};
            7'b0000110: seg_decode = {1'b1, 4'hE};
            7'b0001110: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = 5'b0_0000;
        endcase
    endfunction

    // {valid, digit index}; only a single low anode selects a digit
    function automatic logic [2:0] an_decode(input logic [3:0] an);
        case (an)
            4'b1110: an_decode = 3'b1_00;
            4'b1101: an_decode = 3'b1_01;
            4'b1011: an_decode = 3'b1_10;
            4'b0111: an_decode = 3'b1_11;
            default: an_decode = 3'b0_00;
        endcase
    endfunction

    logic [11:0]    sync1_q, sync1_d;
    logic [11:0]    sync2_q, sync2_d;
    logic [11:0]    prev_q, prev_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [3:0]     shadow_dp_q, shadow_dp_d;
    logic [3:0]     mask_q, mask_d;
    logic [15:0]    value_q, value_d;
    logic [3:0]     dp_q, dp_d;
    logic           valid_q, valid_d;
    logic           digit_err_q, digit_err_d;
    logic           stale_q, stale_d;
    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic       pair_eq;
    logic       accept;
    logic       blank;
    logic       capture;
    logic       complete;
    logic       tmo_reach;
    logic [3:0] an_s;
    logic [7:0] ca_s;
    logic [2:0] an_dec;
    logic [4:0] seg_dec;

    always_comb begin
        sync1_d = {bus.SSEG_AN, bus.SSEG_CA};
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // run length of the synchronized pair; accept fires once per settled pattern
        pair_eq = (sync2_q == prev_q);
        if (!pair_eq) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q == SC_MAX) begin
            settle_cnt_d = settle_cnt_q;
        end else begin
            settle_cnt_d = settle_cnt_q + SCW'(1);
        end
        if (SETTLE_CYCLES == 1) begin
            accept = !pair_eq;
        end else begin
            accept = pair_eq && (settle_cnt_q == SC_FIRE);
        end

        an_s    = sync2_q[11:8];
        ca_s    = sync2_q[7:0];
        an_dec  = an_decode(an_s);
        seg_dec = seg_decode(ca_s[6:0]);
        blank   = (an_s == 4'b1111);
        capture     = accept && !blank && an_dec[2] && seg_dec[4];
        digit_err_d = accept && !blank && !(an_dec[2] && seg_dec[4]);

        complete  = (mask_q == 4'b1111);
        tmo_reach = !complete && (tmo_cnt_q == TMO_HIT);

        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        mask_d      = complete ? 4'b0000 : mask_q;
        if (capture) begin
            shadow_d[{an_dec[1:0], 2'b00} +: 4] = seg_dec[3:0];
            shadow_dp_d[an_dec[1:0]]            = ~ca_s[7];
            mask_d[an_dec[1:0]]                 = 1'b1;
        end
        // a timeout discards whatever partial frame was being assembled
        if (tmo_reach) begin
            mask_d = 4'b0000;
        end

        valid_d = complete;
        value_d = complete ? shadow_q : value_q;
        dp_d    = complete ? shadow_dp_q : dp_q;

        if (complete) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
        stale_d = complete ? 1'b0 : (tmo_reach ? 1'b1 : stale_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q      <= BUS_IDLE;
            sync2_q      <= BUS_IDLE;
            prev_q       <= BUS_IDLE;
            settle_cnt_q <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            dp_q         <= '0;
            valid_q      <= 1'b0;
            digit_err_q  <= 1'b0;
            stale_q      <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            settle_cnt_q <= settle_cnt_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            digit_err_q  <= digit_err_d;
            stale_q      <= stale_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.VALUE     = value_q;
    assign bus.DP        = dp_q;
    assign bus.VALID     = valid_q;
    assign bus.DIGIT_ERR = digit_err_q;
    assign bus.STALE     = stale_q;

endmodule
